// File: rtl/adsr_poly_envelope_pkg.sv
// adsr_poly_envelope_pkg: shared voice state encodings for the ADSR envelope block
package adsr_poly_envelope_pkg;
  localparam int ADSR_STATE_W = 3;
  typedef enum logic [ADSR_STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } adsr_state_e;
endpackage

// File: rtl/adsr_poly_envelope_voice.sv
// adsr_poly_envelope_voice: one ADSR voice with its FSM, level register, gate history and done flag
module adsr_poly_envelope_voice
  import adsr_poly_envelope_pkg::*;
#(
  parameter int ENV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 beat_i,
  input  logic                 gate_i,
  input  logic [ENV_WIDTH-1:0] a_step_i,
  input  logic [ENV_WIDTH-1:0] d_step_i,
  input  logic [ENV_WIDTH-1:0] s_level_i,
  input  logic [ENV_WIDTH-1:0] r_step_i,
  output logic [ENV_WIDTH-1:0] level_o,
  output logic                 active_o,
  output logic                 done_o
);
  adsr_state_e          state_q, state_d;
  logic [ENV_WIDTH-1:0] level_q, level_d;
  logic                 gate_q, done_q, done_d;
  logic                 rise, fall, a_top, d_bot, r_bot;
  logic [ENV_WIDTH:0]   lvl_x, max_x;
  assign rise  = gate_i & ~gate_q;
  assign fall  = ~gate_i & gate_q;
  assign lvl_x = {1'b0, level_q};
  assign max_x = {1'b0, {ENV_WIDTH{1'b1}}};
  // one extra bit keeps the threshold arithmetic free of wrap
  assign a_top = (a_step_i == '0) || (lvl_x >= max_x - {1'b0, a_step_i});
  assign d_bot = (d_step_i == '0) || (lvl_x <= {1'b0, s_level_i} + {1'b0, d_step_i});
  assign r_bot = (r_step_i == '0) || (lvl_x <= {1'b0, r_step_i});
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        level_d = '0;
        state_d = rise ? S_ATTACK : S_IDLE;
      end
      S_ATTACK:
        if (fall) state_d = S_RELEASE;
        else if (beat_i) begin
          level_d = a_top ? '1 : level_q + a_step_i;
          state_d = a_top ? S_DECAY : S_ATTACK;
        end
      S_DECAY:
        if (fall) state_d = S_RELEASE;
        else if (beat_i) begin
          level_d = d_bot ? s_level_i : level_q - d_step_i;
          state_d = d_bot ? S_SUSTAIN : S_DECAY;
        end
      S_SUSTAIN: begin
        level_d = fall ? level_q : s_level_i;
        state_d = fall ? S_RELEASE : S_SUSTAIN;
      end
      S_RELEASE:
        if (rise) state_d = S_ATTACK;
        else if (beat_i) begin
          level_d = r_bot ? '0 : level_q - r_step_i;
          state_d = r_bot ? S_IDLE : S_RELEASE;
          done_d  = r_bot;
        end
      default: begin
        state_d = S_IDLE;
        level_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= gate_i;
      done_q  <= done_d;
    end
  end
  assign level_o  = level_q;
  assign active_o = state_q != S_IDLE;
  assign done_o   = done_q;
endmodule

// File: rtl/adsr_poly_envelope.sv
// adsr_poly_envelope: NUM_VOICES ADSR envelopes sharing one parameter set and beat strobe
module adsr_poly_envelope
  import adsr_poly_envelope_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int ENV_WIDTH   = 16,
  parameter int PARAM_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            beat,
  input  logic [NUM_VOICES-1:0]           gate,
  input  logic [PARAM_WIDTH-1:0]          attack,
  input  logic [PARAM_WIDTH-1:0]          decay,
  input  logic [PARAM_WIDTH-1:0]          sustain,
  input  logic [PARAM_WIDTH-1:0]          released,
  output logic [NUM_VOICES*ENV_WIDTH-1:0] envelope_out,
  output logic [NUM_VOICES-1:0]           voice_active,
  output logic [NUM_VOICES-1:0]           voice_done
);
  localparam int SH = ENV_WIDTH - PARAM_WIDTH;
  logic [ENV_WIDTH-1:0] a_step, d_step, s_level, r_step;
  assign a_step  = ENV_WIDTH'(attack) << SH;
  assign d_step  = ENV_WIDTH'(decay) << SH;
  assign s_level = ENV_WIDTH'(sustain) << SH;
  assign r_step  = ENV_WIDTH'(released) << SH;
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    adsr_poly_envelope_voice #(.ENV_WIDTH(ENV_WIDTH)) u_voice (
      .clk      (clk),
      .reset    (reset),
      .beat_i   (beat),
      .gate_i   (gate[v]),
      .a_step_i (a_step),
      .d_step_i (d_step),
      .s_level_i(s_level),
      .r_step_i (r_step),
      .level_o  (envelope_out[v*ENV_WIDTH +: ENV_WIDTH]),
      .active_o (voice_active[v]),
      .done_o   (voice_done[v])
    );
  end
endmodule
